// File: rtl/cbfp_pkg.sv
// Shared parameters, types and the saturated redundant-sign count for the CBFP path.
// Latency: none (package only).
// Backpressure: none (package only).
package cbfp_pkg;
  localparam int DIN_SIZE   = 23;
  localparam int CNT_SIZE   = 5;
  localparam int ARRAY_NUM  = 4;
  localparam int ARRAY_SIZE = 16;
  localparam int BEAT_W     = $clog2(ARRAY_NUM);

  typedef logic signed [DIN_SIZE-1:0]          sample_t;
  typedef logic signed [CNT_SIZE-1:0]          cnt_t;
  typedef logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0] beat_t;
  typedef cnt_t [ARRAY_NUM-1:0]                cnt_vec_t;

  // Largest positive count representable in a signed cnt_t.
  localparam cnt_t CNT_SAT = cnt_t'((1 << (CNT_SIZE-1)) - 1);

  typedef enum logic {IDLE, REPLAY} rd_state_t;

  // Bits below the sign bit that merely repeat it, i.e. DIN_SIZE minus the
  // minimal two's-complement width; 0 and -1 give DIN_SIZE-1. Saturated.
  function automatic cnt_t sign_cnt(input sample_t s);
    int   cnt;
    logic run;
    cnt = 0;
    run = 1'b1;
    for (int i = DIN_SIZE-2; i >= 0; i--) begin
      if (run && (s[i] == s[DIN_SIZE-1])) cnt = cnt + 1;
      else run = 1'b0;
    end
    if (cnt > int'(CNT_SAT)) cnt = int'(CNT_SAT);
    return cnt_t'(cnt);
  endfunction
endpackage

// File: rtl/cbfp_block_scan_if.sv
// Beat stream into and out of the block-exponent scanner, with frame counts.
// Latency: none (wires only).
// Backpressure: none; the consumer must accept every valid beat.
interface cbfp_block_scan_if;
  import cbfp_pkg::*;

  logic     valid_in;
  beat_t    din;
  logic     valid_out;
  beat_t    dout;
  cnt_vec_t cal_cnt;

  modport master (output valid_in, din, input valid_out, dout, cal_cnt);
  modport slave  (input valid_in, din, output valid_out, dout, cal_cnt);
endinterface

// File: rtl/cbfp_lead_min.sv
// Minimum saturated redundant-sign count across one beat of samples.
// Latency: combinational.
// Backpressure: none.
module cbfp_lead_min
  import cbfp_pkg::*;
(
  input  beat_t din,
  output cnt_t  min_cnt
);
  localparam int NODES = 2*ARRAY_SIZE - 1;

  // Heap-ordered min tree: leaves are per-sample counts, each parent keeps the smaller child.
  always_comb begin
    cnt_t node [NODES];
    for (int i = 0; i < NODES; i++) node[i] = CNT_SAT;
    for (int i = 0; i < ARRAY_SIZE; i++) node[ARRAY_SIZE-1+i] = sign_cnt(sample_t'(din[i]));
    for (int k = ARRAY_SIZE-2; k >= 0; k--)
      node[k] = (node[2*k+1] < node[2*k+2]) ? node[2*k+1] : node[2*k+2];
    min_cnt = node[0];
  end
endmodule

// File: rtl/cbfp_block_scan.sv
// Buffers a frame of beats, finds per-beat exponents, replays frame with frame-constant cal_cnt.
// Latency: contiguous input ARRAY_NUM cycles; gapped input one cycle after the last beat.
// Backpressure: none; ping-pong banks absorb continuous input.
module cbfp_block_scan
  import cbfp_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cbfp_block_scan_if.slave bus
);
  typedef logic [BEAT_W-1:0] beat_idx_t;
  localparam beat_idx_t LAST_BEAT = beat_idx_t'(ARRAY_NUM-1);

  beat_t      data_mem [2][ARRAY_NUM];
  cnt_vec_t   cnt_mem  [2];
  logic [1:0] full;
  logic [1:0] set;
  logic [1:0] clr;
  logic [1:0] avail;
  logic       wr_bank;
  beat_idx_t  wr_beat;
  logic       wr_done;
  cnt_t       beat_cnt;
  cnt_vec_t   cnt_wr;

  rd_state_t  state, state_nx;
  logic       rd_bank, rd_bank_nx;
  beat_idx_t  rd_beat, rd_beat_nx;
  logic       load;

  logic       valid_nx, valid_q;
  beat_t      dout_nx, dout_q;
  cnt_vec_t   cal_nx, cal_q;

  cbfp_lead_min u_lead_min (
    .din     (bus.din),
    .min_cnt (beat_cnt)
  );

  assign wr_done = bus.valid_in && (wr_beat == LAST_BEAT);

  // Count vector of the bank under write including this cycle's beat, so a frame can be loaded the cycle it completes.
  always_comb begin
    cnt_wr = cnt_mem[wr_bank];
    if (bus.valid_in) cnt_wr[wr_beat] = beat_cnt;
    set = '0;
    if (wr_done) set[wr_bank] = 1'b1;
  end

  assign avail = full | set;

  // Write side: store beat and count, mark bank full and flip banks on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_beat <= '0;
      full    <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_mem[b] <= '0;
        for (int j = 0; j < ARRAY_NUM; j++) data_mem[b][j] <= '0;
      end
    end else begin
      if (bus.valid_in) begin
        data_mem[wr_bank][wr_beat] <= bus.din;
        cnt_mem[wr_bank]           <= cnt_wr;
        wr_beat                    <= wr_done ? '0 : wr_beat + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      full <= (full & ~clr) | set;
    end
  end

  // Read FSM state register; rd_beat is the beat currently on dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_beat <= '0;
    end else begin
      state   <= state_nx;
      rd_bank <= rd_bank_nx;
      rd_beat <= rd_beat_nx;
    end
  end

  // Read FSM next state: start on a replayable bank, chain straight into the other bank when it is ready.
  always_comb begin
    state_nx   = state;
    rd_bank_nx = rd_bank;
    rd_beat_nx = rd_beat;
    load       = 1'b0;
    clr        = '0;
    case (state)
      IDLE: begin
        if (avail[rd_bank]) begin
          state_nx   = REPLAY;
          rd_beat_nx = '0;
          load       = 1'b1;
        end
      end
      REPLAY: begin
        if (rd_beat != LAST_BEAT) begin
          rd_beat_nx = rd_beat + 1'b1;
        end else begin
          clr[rd_bank] = 1'b1;
          rd_bank_nx   = ~rd_bank;
          rd_beat_nx   = '0;
          if (avail[~rd_bank]) load = 1'b1;
          else state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read FSM outputs for the next cycle; cal_cnt only changes when a new frame is loaded.
  always_comb begin
    valid_nx = (state_nx == REPLAY);
    dout_nx  = valid_nx ? data_mem[rd_bank_nx][rd_beat_nx] : '0;
    cal_nx   = cal_q;
    if (load) cal_nx = (rd_bank_nx == wr_bank) ? cnt_wr : cnt_mem[rd_bank_nx];
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
      cal_q   <= '0;
    end else begin
      valid_q <= valid_nx;
      dout_q  <= dout_nx;
      cal_q   <= cal_nx;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.dout      = dout_q;
  assign bus.cal_cnt   = cal_q;

  // Replay frees a bank in exactly ARRAY_NUM cycles, never slower than the writer can refill it.
  a_no_overrun: assert property (@(posedge clk) disable iff (rst) !(bus.valid_in && full[wr_bank]));
endmodule
